// File: rtl/tc_sram_bist.sv
// March C- self-test controller for a single-port tc_sram_impl macro.
// Owns the SRAM request port while busy_o is high and reports the first mismatch seen.
module tc_sram_bist #(
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned ByteWidth = 8,
    parameter int unsigned Latency   = 1,
    parameter int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
    parameter int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 fail_o,
    output logic [AddrWidth-1:0] fail_addr_o,
    output logic [DataWidth-1:0] fail_syndrome_o,
    output logic                 req_o,
    output logic                 we_o,
    output logic [AddrWidth-1:0] addr_o,
    output logic [DataWidth-1:0] wdata_o,
    output logic [BeWidth-1:0]   be_o,
    input  logic [DataWidth-1:0] rdata_i
);

    typedef enum logic [3:0] {
        IDLE,
        M0,
        M1,
        M2,
        M3,
        M4,
        M5,
        DRAIN,
        DONE
    } state_e;

    localparam logic [AddrWidth-1:0] LastAddr  = AddrWidth'(NumWords - 1);
    localparam int unsigned          CntW      = (Latency > 1) ? $clog2(Latency) : 1;
    localparam logic [CntW-1:0]      DrainInit = CntW'(Latency - 1);

    function automatic logic elem_down(input state_e s);
        return (s == M3) || (s == M4) || (s == M5);
    endfunction

    function automatic logic elem_two_phase(input state_e s);
        return (s == M1) || (s == M2) || (s == M3) || (s == M4);
    endfunction

    function automatic logic elem_march(input state_e s);
        return (s == M0) || elem_two_phase(s) || (s == M5);
    endfunction

    // Background written by the second op of each element (M1/M3 write ones).
    function automatic logic write_bg(input state_e s);
        return (s == M1) || (s == M3);
    endfunction

    // Background expected by the read op of each element (M2/M4 read ones).
    function automatic logic read_bg(input state_e s);
        return (s == M2) || (s == M4);
    endfunction

    function automatic state_e next_elem(input state_e s);
        state_e n;
        case (s)
            M0:      n = M1;
            M1:      n = M2;
            M2:      n = M3;
            M3:      n = M4;
            M4:      n = M5;
            default: n = DRAIN;
        endcase
        return n;
    endfunction

    function automatic logic [DataWidth-1:0] syndrome(input logic [DataWidth-1:0] rd,
                                                      input logic                 bg);
        return rd ^ {DataWidth{bg}};
    endfunction

    state_e                 state_q, state_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic                   phase_q, phase_d;
    logic [CntW-1:0]        drain_q, drain_d;
    logic                   req_q, req_d;
    logic                   we_q, we_d;
    logic [DataWidth-1:0]   wdata_q, wdata_d;
    logic [BeWidth-1:0]     be_q, be_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   fail_q;
    logic [AddrWidth-1:0]   fail_addr_q;
    logic [DataWidth-1:0]   fail_syn_q;

    logic                   start_accept;
    logic                   terminal;
    state_e                 elem_n;
    logic                   march_d;

    // Read-check pipeline: one slot per cycle of SRAM read latency.
    logic                   rd_vld_p  [Latency];
    logic [AddrWidth-1:0]   rd_addr_p [Latency];
    logic                   rd_exp_p  [Latency];
    logic [DataWidth-1:0]   rd_syn;
    logic                   mismatch;

    assign start_accept = start_i && ((state_q == IDLE) || (state_q == DONE));

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        phase_d  = phase_q;
        drain_d  = drain_q;
        elem_n   = next_elem(state_q);
        terminal = (elem_down(state_q) ? (addr_q == '0) : (addr_q == LastAddr)) &&
                   (!elem_two_phase(state_q) || phase_q);

        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d = M0;
                    addr_d  = '0;
                    phase_d = 1'b0;
                end
            end
            M0, M1, M2, M3, M4, M5: begin
                if (terminal) begin
                    state_d = elem_n;
                    phase_d = 1'b0;
                    if (elem_n == DRAIN) begin
                        addr_d  = '0;
                        drain_d = DrainInit;
                    end else begin
                        addr_d = elem_down(elem_n) ? LastAddr : '0;
                    end
                end else if (elem_two_phase(state_q) && !phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    addr_d  = elem_down(state_q) ? (addr_q - 1'b1) : (addr_q + 1'b1);
                end
            end
            DRAIN: begin
                if (drain_q == '0) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                addr_d  = '0;
                phase_d = 1'b0;
            end
        endcase

        // Request outputs are derived from the next op so they leave the flops clean.
        march_d = elem_march(state_d);
        req_d   = march_d;
        we_d    = march_d && ((state_d == M0) || (elem_two_phase(state_d) && phase_d));
        wdata_d = we_d ? {DataWidth{write_bg(state_d)}} : '0;
        be_d    = {BeWidth{march_d}};
        busy_d  = march_d || (state_d == DRAIN);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            phase_q <= 1'b0;
            drain_q <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            phase_q <= phase_d;
            drain_q <= drain_d;
            req_q   <= req_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Stage p0 captures the op on the bus this cycle; slot Latency-1 lines up with rdata_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Latency; i++) begin
                rd_vld_p[i] <= 1'b0;
            end
        end else begin
            rd_vld_p[0] <= req_q && !we_q && !start_accept;
            for (int i = 1; i < Latency; i++) begin
                rd_vld_p[i] <= rd_vld_p[i-1] && !start_accept;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        rd_addr_p[0] <= addr_q;
        rd_exp_p[0]  <= read_bg(state_q);
        for (int i = 1; i < Latency; i++) begin
            rd_addr_p[i] <= rd_addr_p[i-1];
            rd_exp_p[i]  <= rd_exp_p[i-1];
        end
    end

    assign rd_syn   = syndrome(rdata_i, rd_exp_p[Latency-1]);
    assign mismatch = rd_vld_p[Latency-1] && (rd_syn != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_syn_q  <= '0;
        end else if (start_accept) begin
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_syn_q  <= '0;
        end else if (mismatch && !fail_q) begin
            fail_q      <= 1'b1;
            fail_addr_q <= rd_addr_p[Latency-1];
            fail_syn_q  <= rd_syn;
        end
    end

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign fail_o          = fail_q;
    assign fail_addr_o     = fail_addr_q;
    assign fail_syndrome_o = fail_syn_q;
    assign req_o           = req_q;
    assign we_o            = we_q;
    assign addr_o          = addr_q;
    assign wdata_o         = wdata_q;
    assign be_o            = be_q;

endmodule

// File: tb/tb_tc_sram_bist.sv
// Bench for tc_sram_bist: two instances (16x32 latency 1, 12x32 latency 3) against
// behavioural SRAMs with injectable stuck-at and up-transition faults.
module tb_tc_sram_bist;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        a_start, a_busy, a_done, a_fail, a_req, a_we;
    logic [3:0]  a_faddr, a_addr, a_be;
    logic [31:0] a_syn, a_wdata, a_rdata;

    logic        b_start, b_busy, b_done, b_fail, b_req, b_we;
    logic [3:0]  b_faddr, b_addr, b_be;
    logic [31:0] b_syn, b_wdata, b_rdata;

    tc_sram_bist #(.NumWords(16), .DataWidth(32), .ByteWidth(8), .Latency(1)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .start_i(a_start), .busy_o(a_busy), .done_o(a_done),
        .fail_o(a_fail), .fail_addr_o(a_faddr), .fail_syndrome_o(a_syn), .req_o(a_req),
        .we_o(a_we), .addr_o(a_addr), .wdata_o(a_wdata), .be_o(a_be), .rdata_i(a_rdata)
    );

    tc_sram_bist #(.NumWords(12), .DataWidth(32), .ByteWidth(8), .Latency(3)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .start_i(b_start), .busy_o(b_busy), .done_o(b_done),
        .fail_o(b_fail), .fail_addr_o(b_faddr), .fail_syndrome_o(b_syn), .req_o(b_req),
        .we_o(b_we), .addr_o(b_addr), .wdata_o(b_wdata), .be_o(b_be), .rdata_i(b_rdata)
    );

    // Fault selection for memory A: 0 none, 1 stuck-at-1, 2 up-transition,
    // 3 stuck-at-1 at (faddr,fbit) plus stuck-at-0 on bit 2 of address 9.
    int ftype = 0;
    int faddr = 0;
    int fbit  = 0;

    function automatic logic [31:0] flt_rd(input int a, input logic [31:0] d);
        logic [31:0] r;
        r = d;
        if ((ftype == 1 || ftype == 3) && a == faddr) r[fbit] = 1'b1;
        if (ftype == 3 && a == 9) r[2] = 1'b0;
        return r;
    endfunction

    function automatic logic [31:0] flt_wr(input int a, input logic [31:0] o, input logic [31:0] n);
        logic [31:0] r;
        r = n;
        if (ftype == 2 && a == faddr && !o[fbit]) r[fbit] = 1'b0;
        return r;
    endfunction

    logic [31:0] mem_a [16];
    logic [31:0] rd_a;
    always @(posedge clk) begin
        if (a_req) begin
            if (a_we) mem_a[a_addr] <= flt_wr(int'(a_addr), mem_a[a_addr], a_wdata);
            else      rd_a <= flt_rd(int'(a_addr), mem_a[a_addr]);
        end
    end
    assign a_rdata = rd_a;

    logic [31:0] mem_b [12];
    logic [31:0] rd_b [3];
    always @(posedge clk) begin
        rd_b[0] <= 32'h0;
        rd_b[1] <= rd_b[0];
        rd_b[2] <= rd_b[1];
        if (b_req && b_addr < 4'd12) begin
            if (b_we) mem_b[b_addr] <= b_wdata;
            else      rd_b[0] <= mem_b[b_addr];
        end
    end
    assign b_rdata = rd_b[2];

    int          sel = 0;
    logic        m_req, m_we, m_busy, m_done, m_fail;
    logic [3:0]  m_addr, m_faddr, m_be;
    logic [31:0] m_wdata, m_syn;
    always_comb begin
        if (sel == 1) begin
            m_req = b_req; m_we = b_we; m_busy = b_busy; m_done = b_done; m_fail = b_fail;
            m_addr = b_addr; m_faddr = b_faddr; m_be = b_be; m_wdata = b_wdata; m_syn = b_syn;
        end else begin
            m_req = a_req; m_we = a_we; m_busy = a_busy; m_done = a_done; m_fail = a_fail;
            m_addr = a_addr; m_faddr = a_faddr; m_be = a_be; m_wdata = a_wdata; m_syn = a_syn;
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic we;
        int   addr;
        logic bg;
    } op_t;
    op_t exp_q[$];

    function automatic op_t mk(input logic we, input int a, input logic bg);
        op_t o;
        o.we = we; o.addr = a; o.bg = bg;
        return o;
    endfunction

    task automatic build(input int n);
        exp_q.delete();
        for (int a = 0; a < n; a++) exp_q.push_back(mk(1'b1, a, 1'b0));
        for (int a = 0; a < n; a++) begin exp_q.push_back(mk(1'b0, a, 1'b0)); exp_q.push_back(mk(1'b1, a, 1'b1)); end
        for (int a = 0; a < n; a++) begin exp_q.push_back(mk(1'b0, a, 1'b1)); exp_q.push_back(mk(1'b1, a, 1'b0)); end
        for (int a = n - 1; a >= 0; a--) begin exp_q.push_back(mk(1'b0, a, 1'b0)); exp_q.push_back(mk(1'b1, a, 1'b1)); end
        for (int a = n - 1; a >= 0; a--) begin exp_q.push_back(mk(1'b0, a, 1'b1)); exp_q.push_back(mk(1'b1, a, 1'b0)); end
        for (int a = n - 1; a >= 0; a--) exp_q.push_back(mk(1'b0, a, 1'b0));
    endtask

    typedef struct {
        int          sel;
        int          ftype;
        int          faddr;
        int          fbit;
        int          nwords;
        int          exp_done;
        logic        exp_fail;
        int          exp_faddr;
        logic [31:0] exp_syn;
        int          exp_fail_k;
        int          pulse_k;
        int          mid_k;
    } vec_t;

    task automatic run_vec(input vec_t v);
        int k, nreq, seqerr, first_req, last_req, gaps, done_k, fail_k, max_addr, m3_first;
        ftype = v.ftype; faddr = v.faddr; fbit = v.fbit; sel = v.sel;
        build(v.nwords);
        nreq = 0; seqerr = 0; first_req = 0; last_req = 0; gaps = 0;
        done_k = 0; fail_k = 0; max_addr = 0; m3_first = -1;
        @(negedge clk);
        if (v.sel == 0) a_start = 1'b1; else b_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0; b_start = 1'b0;
        k = 1;
        while (done_k == 0 && k <= 400) begin
            if (k == 1) begin
                chk("start_busy", 64'(m_busy), 64'd1);
                chk("start_done_clr", 64'(m_done), 64'd0);
                chk("start_fail_clr", 64'(m_fail), 64'd0);
                chk("start_faddr_clr", 64'(m_faddr), 64'd0);
                chk("start_syn_clr", 64'(m_syn), 64'd0);
            end
            if (m_req) begin
                if (first_req == 0) first_req = k;
                if (last_req != 0 && last_req != k - 1) gaps++;
                last_req = k;
                if (nreq < exp_q.size()) begin
                    if (m_we !== exp_q[nreq].we || int'(m_addr) != exp_q[nreq].addr || m_be !== 4'hF ||
                        (m_we && m_wdata !== {32{exp_q[nreq].bg}})) seqerr++;
                end else begin
                    seqerr++;
                end
                if (nreq == 5 * v.nwords) m3_first = int'(m_addr);
                if (int'(m_addr) > max_addr) max_addr = int'(m_addr);
                nreq++;
            end
            if (m_fail && fail_k == 0) fail_k = k;
            if (m_done) done_k = k;
            if (v.mid_k != 0 && k == v.mid_k) begin
                chk("mid_faddr_held", 64'(m_faddr), 64'(v.exp_faddr));
                chk("mid_syn_held", 64'(m_syn), 64'(v.exp_syn));
            end
            if (v.pulse_k != 0 && v.sel == 0) a_start = (k == v.pulse_k);
            if (done_k == 0) begin
                @(negedge clk);
                k++;
            end
        end
        a_start = 1'b0;
        chk("done_cycle", 64'(done_k), 64'(v.exp_done));
        chk("req_count", 64'(nreq), 64'(10 * v.nwords));
        chk("seq_errors", 64'(seqerr), 64'd0);
        chk("first_req_cycle", 64'(first_req), 64'd1);
        chk("req_gaps", 64'(gaps), 64'd0);
        chk("max_addr", 64'(max_addr), 64'(v.nwords - 1));
        chk("m3_start_addr", 64'(m3_first), 64'(v.nwords - 1));
        chk("done_busy", 64'(m_busy), 64'd0);
        chk("done_req", 64'(m_req), 64'd0);
        chk("fail_flag", 64'(m_fail), 64'(v.exp_fail));
        if (v.exp_fail) begin
            chk("fail_addr", 64'(m_faddr), 64'(v.exp_faddr));
            chk("fail_syndrome", 64'(m_syn), 64'(v.exp_syn));
            chk("fail_rise_cycle", 64'(fail_k), 64'(v.exp_fail_k));
        end
    endtask

    vec_t vecs[6];
    vec_t post;

    initial begin
        rst_n = 1'b0; a_start = 1'b0; b_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_a_req", 64'(a_req), 64'd0);
        chk("rst_a_busy", 64'(a_busy), 64'd0);
        chk("rst_a_done", 64'(a_done), 64'd0);
        chk("rst_a_fail", 64'(a_fail), 64'd0);
        chk("rst_a_addr_be", 64'({a_addr, a_be}), 64'd0);
        chk("rst_b_req", 64'(b_req), 64'd0);
        chk("rst_b_busy_done", 64'({b_busy, b_done}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_a_req", 64'(a_req), 64'd0);

        //          sel ft fa fb  N  done fail faddr syn         fk  pulse mid
        vecs[0] = '{0,  0, 0, 0, 16, 162, 1'b0, 0,  32'h0,        0,  0,   0};
        vecs[1] = '{0,  1, 3, 5, 16, 162, 1'b1, 3,  32'h0000_0020, 25, 0,   0};
        vecs[2] = '{0,  2, 15, 0, 16, 162, 1'b1, 15, 32'h0000_0001, 81, 0,   0};
        vecs[3] = '{0,  3, 3, 5, 16, 162, 1'b1, 3,  32'h0000_0020, 25, 0,   70};
        vecs[4] = '{0,  0, 0, 0, 16, 162, 1'b0, 0,  32'h0,        0,  30,  0};
        vecs[5] = '{1,  0, 0, 0, 12, 124, 1'b0, 0,  32'h0,        0,  0,   0};
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Asynchronous reset mid-M2 on a failing run, then a clean full rerun.
        ftype = 1; faddr = 3; fbit = 5; sel = 0;
        @(negedge clk); a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        repeat (49) @(negedge clk);
        chk("pre_rst_req", 64'(a_req), 64'd1);
        chk("pre_rst_fail", 64'(a_fail), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_req", 64'(a_req), 64'd0);
        chk("abort_busy", 64'(a_busy), 64'd0);
        chk("abort_done", 64'(a_done), 64'd0);
        chk("abort_fail", 64'(a_fail), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        post = '{0, 0, 0, 0, 16, 162, 1'b0, 0, 32'h0, 0, 0, 0};
        run_vec(post);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
